// File: rtl/psone_pad_master_pkg.sv
// Shared definitions for the PlayStation pad poll master: state encoding,
// command/marker byte constants and small elaboration helpers.
package psone_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ATT_SETUP,
        S_CLK_LOW,
        S_CLK_HIGH,
        S_ACK_WAIT,
        S_BYTE_GAP,
        S_DONE,
        S_ERROR,
        S_ATT_HOLD
    } state_t;

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_POLL  = 8'h42;
    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] RX_MARKER = 8'h5A;
    localparam int         LAST_BYTE = 4;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = CMD_START;
            3'd1:    cmd_byte = CMD_POLL;
            default: cmd_byte = CMD_IDLE;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/psone_pad_master_if.sv
// Pad-side and host-side signals of the poll master, bundled for port use.
interface psone_pad_master_if;
    logic        iPOLL_ST;
    logic        iPAD_DAT;
    logic        iPAD_ACK;
    logic        oPAD_ATT;
    logic        oPAD_CLK;
    logic        oPAD_CMD;
    logic [15:0] oBUTTONS;
    logic [7:0]  oPAD_ID;
    logic        oPOLL_END;
    logic        oPOLL_ER;
    logic        oBUSY;

    modport master (
        input  iPOLL_ST, iPAD_DAT, iPAD_ACK,
        output oPAD_ATT, oPAD_CLK, oPAD_CMD, oBUTTONS, oPAD_ID,
               oPOLL_END, oPOLL_ER, oBUSY
    );

    modport slave (
        output iPOLL_ST, iPAD_DAT, iPAD_ACK,
        input  oPAD_ATT, oPAD_CLK, oPAD_CMD, oBUTTONS, oPAD_ID,
               oPOLL_END, oPOLL_ER, oBUSY
    );
endinterface

// File: rtl/psone_pad_master_sync2.sv
// Two-flop synchroniser for the asynchronous pad lines; resets to the idle-high level.
module psone_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            q  <= 1'b1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/psone_pad_master.sv
// Polls a digital PlayStation pad: 5-byte exchange (01 42 00 00 00), checks the
// 0x5A marker, and publishes ID and button words on a clean poll.
module psone_pad_master
    import psone_pkg::*;
#(
    parameter int CLK_HALF    = 100,
    parameter int ATT_SETUP   = 1000,
    parameter int ACK_TIMEOUT = 5000
) (
    input  logic iCLK,
    input  logic iRESET,
    psone_pad_master_if.master pad
);
    localparam int CW = $clog2(max3(ATT_SETUP, ACK_TIMEOUT, 2 * CLK_HALF)) + 1;
    localparam logic [CW-1:0] LD_ATT  = CW'(ATT_SETUP - 1);
    localparam logic [CW-1:0] LD_HALF = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] LD_GAP  = CW'(2 * CLK_HALF - 1);
    localparam logic [CW-1:0] LD_ACK  = CW'(ACK_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]  byte_idx, bit_idx;
    logic [6:0]  rx_sh;
    logic [7:0]  id_sh, btn_lo, cmd_cur, pad_id;
    logic [15:0] buttons;
    logic        dat_s, ack_s;

    wire        cnt_end  = (cnt == '0);
    wire        last_bit = (bit_idx == 3'd7);
    wire [7:0]  rx_byte  = {dat_s, rx_sh};
    assign cmd_cur = cmd_byte(byte_idx);

    psone_sync2 u_sync_dat (.clk(iCLK), .rst_n(iRESET), .d(pad.iPAD_DAT), .q(dat_s));
    psone_sync2 u_sync_ack (.clk(iCLK), .rst_n(iRESET), .d(pad.iPAD_ACK), .q(ack_s));

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (pad.iPOLL_ST) state_nx = S_ATT_SETUP;
            S_ATT_SETUP: if (cnt_end) state_nx = S_CLK_LOW;
            S_CLK_LOW:   if (cnt_end) state_nx = S_CLK_HIGH;
            S_CLK_HIGH:
                if (cnt_end) begin
                    if (!last_bit)                                 state_nx = S_CLK_LOW;
                    else if (byte_idx == 3'(LAST_BYTE))            state_nx = S_DONE;
                    else if (byte_idx == 3'd2 && rx_byte != RX_MARKER) state_nx = S_ERROR;
                    else                                           state_nx = S_ACK_WAIT;
                end
            S_ACK_WAIT:
                if (!ack_s)       state_nx = S_BYTE_GAP;
                else if (cnt_end) state_nx = S_ERROR;
            S_BYTE_GAP:  if (cnt_end) state_nx = S_CLK_LOW;
            S_DONE,
            S_ERROR:     state_nx = S_ATT_HOLD;
            S_ATT_HOLD:  if (cnt_end) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Every state is timed by the one counter, reloaded on each state entry.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cnt      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            rx_sh    <= '0;
            id_sh    <= 8'hFF;
            btn_lo   <= 8'hFF;
            buttons  <= 16'hFFFF;
            pad_id   <= 8'hFF;
        end else begin
            if (state_nx != state) begin
                case (state_nx)
                    S_ATT_SETUP, S_ATT_HOLD: cnt <= LD_ATT;
                    S_CLK_LOW, S_CLK_HIGH:   cnt <= LD_HALF;
                    S_ACK_WAIT:              cnt <= LD_ACK;
                    S_BYTE_GAP:              cnt <= LD_GAP;
                    default:                 cnt <= '0;
                endcase
            end else if (!cnt_end) begin
                cnt <= cnt - 1'b1;
            end

            if (state == S_IDLE) begin
                byte_idx <= '0;
                bit_idx  <= '0;
            end else if (state == S_CLK_HIGH && cnt_end) begin
                rx_sh   <= rx_byte[7:1];
                bit_idx <= bit_idx + 3'd1;
                if (last_bit) begin
                    byte_idx <= byte_idx + 3'd1;
                    if (byte_idx == 3'd1) id_sh  <= rx_byte;
                    if (byte_idx == 3'd3) btn_lo <= rx_byte;
                    // Final byte goes straight to the outputs alongside the DONE pulse.
                    if (byte_idx == 3'(LAST_BYTE)) begin
                        buttons <= {rx_byte, btn_lo};
                        pad_id  <= id_sh;
                    end
                end
            end
        end
    end

    always_comb begin
        pad.oPAD_ATT  = 1'b1;
        pad.oPAD_CLK  = 1'b1;
        pad.oPAD_CMD  = 1'b1;
        pad.oPOLL_END = (state == S_DONE);
        pad.oPOLL_ER  = (state == S_ERROR);
        pad.oBUSY     = (state != S_IDLE);
        case (state)
            S_ATT_SETUP, S_ACK_WAIT, S_BYTE_GAP: pad.oPAD_ATT = 1'b0;
            S_CLK_LOW: begin
                pad.oPAD_ATT = 1'b0;
                pad.oPAD_CLK = 1'b0;
                pad.oPAD_CMD = cmd_cur[bit_idx];
            end
            S_CLK_HIGH: begin
                pad.oPAD_ATT = 1'b0;
                pad.oPAD_CMD = cmd_cur[bit_idx];
            end
            default: ;
        endcase
    end

    assign pad.oBUTTONS = buttons;
    assign pad.oPAD_ID  = pad_id;
endmodule

// File: tb/tb_psone_pad_master.sv
// Bench for psone_pad_master: behavioural pad model plus scenario tasks,
// run with scaled timing parameters to keep the run short.
module tb_psone_pad_master;
    localparam int CH = 4;
    localparam int AS = 40;
    localparam int AT = 200;

    logic iCLK = 1'b0;
    logic iRESET = 1'b0;
    psone_pad_master_if pad ();

    psone_pad_master #(.CLK_HALF(CH), .ATT_SETUP(AS), .ACK_TIMEOUT(AT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .pad(pad)
    );

    always #5 iCLK = ~iCLK;

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // pad configuration (written by scenarios only)
    logic [7:0] tx [5];
    bit         ack_en [4];
    int         ack_dly = 1;

    // pad model / monitor state (written by the monitor only)
    int nbits = 0, n_end = 0, n_er = 0, bad_start = 0;
    int att_fall_cyc = 0, att_rise_cyc = 0, att_hi_len = 0, busy_fall_cyc = 0, er_cyc = 0;
    int fall_cyc [40];
    int rise_cyc [40];
    int ack_cyc [4];
    logic [7:0] cmd_rx [5];
    int ack_cnt = 0, ack_len = 0;
    logic p_att = 1'b1, p_clk = 1'b1, p_busy = 1'b0;

    always @(negedge iCLK) begin
        if (!iRESET) begin
            ack_cnt = 0;
            ack_len = 0;
            pad.iPAD_ACK = 1'b1;
            pad.iPAD_DAT = 1'b1;
        end else begin
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    pad.iPAD_ACK = 1'b0;
                    ack_len = 4;
                    ack_cyc[nbits / 8 - 1] = cyc;
                end
            end else if (ack_len > 0) begin
                ack_len--;
                if (ack_len == 0) pad.iPAD_ACK = 1'b1;
            end
        end
        if (p_att && !pad.oPAD_ATT) begin
            att_fall_cyc = cyc;
            att_hi_len = cyc - att_rise_cyc;
            nbits = 0;
            if (p_busy) bad_start++;
        end
        if (!p_att && pad.oPAD_ATT) begin
            att_rise_cyc = cyc;
            pad.iPAD_DAT = 1'b1;
        end
        if (p_clk && !pad.oPAD_CLK && nbits < 40) begin
            fall_cyc[nbits] = cyc;
            pad.iPAD_DAT = tx[nbits / 8][nbits % 8];
        end
        if (!p_clk && pad.oPAD_CLK && !pad.oPAD_ATT && nbits < 40) begin
            rise_cyc[nbits] = cyc;
            cmd_rx[nbits / 8][nbits % 8] = pad.oPAD_CMD;
            nbits++;
            if (nbits % 8 == 0 && nbits < 40 && ack_en[nbits / 8 - 1]) ack_cnt = CH + ack_dly;
        end
        if (pad.oPOLL_END) n_end++;
        if (pad.oPOLL_ER) begin
            n_er++;
            er_cyc = cyc;
        end
        if (p_busy && !pad.oBUSY) busy_fall_cyc = cyc;
        p_att  = pad.oPAD_ATT;
        p_clk  = pad.oPAD_CLK;
        p_busy = pad.oBUSY;
    end

    task automatic set_pad(input logic [7:0] id, input logic [7:0] mk, input logic [15:0] btn);
        tx[0] = 8'hFF; tx[1] = id; tx[2] = mk; tx[3] = btn[7:0]; tx[4] = btn[15:8];
        for (int i = 0; i < 4; i++) ack_en[i] = 1'b1;
        ack_dly = $urandom_range(1, 10);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (pad.oBUSY && n < 20000) begin
            @(negedge iCLK);
            n++;
        end
        tests++;
        if (pad.oBUSY) begin
            fails++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, pad.oBUSY, n);
        end
        repeat (2) @(negedge iCLK);
    endtask

    task automatic do_poll(input string name);
        @(negedge iCLK) pad.iPOLL_ST = 1'b1;
        @(negedge iCLK) pad.iPOLL_ST = 1'b0;
        wait_idle(name);
    endtask

    task automatic check_result(input string name, input int end0, input logic [7:0] id, input logic [15:0] btn);
        tests++;
        if (n_end - end0 !== 1) begin fails++; $display("FAIL %s_end: got %0d pulses, required 1", name, n_end - end0); end
        tests++;
        if (pad.oPAD_ID !== id) begin fails++; $display("FAIL %s_id: got %h, required %h", name, pad.oPAD_ID, id); end
        tests++;
        if (pad.oBUTTONS !== btn) begin fails++; $display("FAIL %s_btn: got %h, required %h", name, pad.oBUTTONS, btn); end
    endtask

    task automatic test_reset;
        pad.iPOLL_ST = 1'b0;
        repeat (3) @(negedge iCLK);
        tests++;
        if ({pad.oPAD_ATT, pad.oPAD_CLK, pad.oPAD_CMD, pad.oPOLL_END, pad.oPOLL_ER, pad.oBUSY} !== 6'b111000) begin
            fails++;
            $display("FAIL reset_ctl: got %b, required 111000",
                     {pad.oPAD_ATT, pad.oPAD_CLK, pad.oPAD_CMD, pad.oPOLL_END, pad.oPOLL_ER, pad.oBUSY});
        end
        tests++;
        if ({pad.oBUTTONS, pad.oPAD_ID} !== 24'hFFFFFF) begin
            fails++;
            $display("FAIL reset_out: got %h/%h, required ffff/ff", pad.oBUTTONS, pad.oPAD_ID);
        end
        iRESET = 1'b1;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_nominal;
        logic [7:0] exp_cmd [5];
        int end0 = n_end, er0 = n_er, bad_ph = 0, bad_gap = 0;
        exp_cmd = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        set_pad(8'h41, 8'h5A, 16'h7FFE);
        do_poll("nominal");
        check_result("nominal", end0, 8'h41, 16'h7FFE);
        tests++;
        if (n_er !== er0) begin fails++; $display("FAIL nominal_er: got %0d, required %0d", n_er, er0); end
        for (int b = 0; b < 5; b++) begin
            tests++;
            if (cmd_rx[b] !== exp_cmd[b]) begin fails++; $display("FAIL nominal_cmd%0d: got %h, required %h", b, cmd_rx[b], exp_cmd[b]); end
        end
        tests++;
        if (fall_cyc[0] - att_fall_cyc !== AS) begin
            fails++; $display("FAIL att_setup: got %0d cycles, required %0d", fall_cyc[0] - att_fall_cyc, AS);
        end
        for (int k = 0; k < 40; k++) begin
            if (rise_cyc[k] - fall_cyc[k] != CH) bad_ph++;
            if (k % 8 != 7 && fall_cyc[k + 1] - rise_cyc[k] != CH) bad_ph++;
        end
        tests++;
        if (bad_ph !== 0) begin fails++; $display("FAIL clk_phase: got %0d wrong phases, required 0", bad_ph); end
        // ACK seen after two sync stages plus one decision edge, then the gap
        for (int b = 0; b < 4; b++)
            if (fall_cyc[8 * (b + 1)] - ack_cyc[b] != 2 * CH + 3) bad_gap++;
        tests++;
        if (bad_gap !== 0) begin fails++; $display("FAIL byte_gap: got %0d wrong gaps, required 0", bad_gap); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  id  = 8'($urandom);
            logic [15:0] btn = 16'($urandom);
            int end0 = n_end;
            set_pad(id, 8'h5A, btn);
            do_poll("random");
            check_result("random", end0, id, btn);
        end
    endtask

    task automatic test_timeout;
        logic [15:0] btn0 = pad.oBUTTONS;
        int end0 = n_end, er0 = n_er;
        set_pad(8'($urandom), 8'h5A, 16'($urandom));
        ack_en[1] = 1'b0;
        do_poll("timeout");
        tests++;
        if (n_er - er0 !== 1 || n_end !== end0) begin
            fails++; $display("FAIL timeout_pulse: got er=%0d end=%0d, required er=1 end=0", n_er - er0, n_end - end0);
        end
        tests++;
        if (er_cyc - rise_cyc[15] !== CH + AT) begin
            fails++; $display("FAIL timeout_time: got %0d, required %0d", er_cyc - rise_cyc[15], CH + AT);
        end
        tests++;
        if (att_rise_cyc !== er_cyc) begin fails++; $display("FAIL timeout_att: got %0d, required %0d", att_rise_cyc, er_cyc); end
        tests++;
        if (busy_fall_cyc - er_cyc !== AS + 1) begin
            fails++; $display("FAIL timeout_hold: got %0d, required %0d", busy_fall_cyc - er_cyc, AS + 1);
        end
        tests++;
        if (pad.oBUTTONS !== btn0 || nbits !== 16) begin
            fails++; $display("FAIL timeout_keep: got btn=%h bits=%0d, required %h/16", pad.oBUTTONS, nbits, btn0);
        end
    endtask

    task automatic test_bad_marker;
        logic [15:0] btn0 = pad.oBUTTONS;
        int end0 = n_end, er0 = n_er;
        set_pad(8'h41, 8'h00, 16'h1234);
        do_poll("marker");
        tests++;
        if (n_er - er0 !== 1 || n_end !== end0) begin
            fails++; $display("FAIL marker_pulse: got er=%0d end=%0d, required er=1 end=0", n_er - er0, n_end - end0);
        end
        tests++;
        if (nbits !== 24) begin fails++; $display("FAIL marker_bits: got %0d, required 24", nbits); end
        tests++;
        if (pad.oBUTTONS !== btn0) begin fails++; $display("FAIL marker_keep: got %h, required %h", pad.oBUTTONS, btn0); end
    endtask

    task automatic test_reset_mid;
        int n = 0, end0;
        logic [7:0]  id  = 8'($urandom);
        logic [15:0] btn = 16'($urandom);
        set_pad(8'h33, 8'h5A, 16'h0F0F);
        @(negedge iCLK) pad.iPOLL_ST = 1'b1;
        @(negedge iCLK) pad.iPOLL_ST = 1'b0;
        while (nbits < 26 && n < 5000) begin @(negedge iCLK); n++; end
        tests++;
        if (nbits < 26) begin fails++; $display("FAIL rstmid_reach: got %0d bits, required 26", nbits); end
        iRESET = 1'b0;
        #1;
        tests++;
        if ({pad.oPAD_ATT, pad.oPAD_CLK, pad.oPAD_CMD, pad.oBUSY} !== 4'b1110 || pad.oBUTTONS !== 16'hFFFF) begin
            fails++; $display("FAIL rstmid_out: got %b btn=%h, required 1110 ffff",
                              {pad.oPAD_ATT, pad.oPAD_CLK, pad.oPAD_CMD, pad.oBUSY}, pad.oBUTTONS);
        end
        @(negedge iCLK) iRESET = 1'b1;
        @(negedge iCLK);
        end0 = n_end;
        set_pad(id, 8'h5A, btn);
        do_poll("rstmid");
        check_result("rstmid", end0, id, btn);
    endtask

    task automatic test_back_to_back;
        int n = 0, end0 = n_end, bad0 = bad_start;
        logic [7:0]  id  = 8'($urandom);
        logic [15:0] btn = 16'($urandom);
        set_pad(id, 8'h5A, btn);
        @(negedge iCLK) pad.iPOLL_ST = 1'b1;
        while (n_end < end0 + 2 && n < 5000) begin @(negedge iCLK); n++; end
        pad.iPOLL_ST = 1'b0;
        wait_idle("b2b");
        tests++;
        if (n_end - end0 !== 2) begin fails++; $display("FAIL b2b_count: got %0d polls, required 2", n_end - end0); end
        tests++;
        if (att_hi_len < AS) begin fails++; $display("FAIL b2b_gap: got %0d cycles ATT high, required >= %0d", att_hi_len, AS); end
        tests++;
        if (bad_start !== bad0) begin fails++; $display("FAIL b2b_busy: got %0d starts while busy, required 0", bad_start - bad0); end
        tests++;
        if (pad.oBUTTONS !== btn || pad.oPAD_ID !== id) begin
            fails++; $display("FAIL b2b_data: got %h/%h, required %h/%h", pad.oBUTTONS, pad.oPAD_ID, btn, id);
        end
    endtask

    initial begin
        pad.iPOLL_ST = 1'b0;
        test_reset();
        test_nominal();
        test_random();
        test_timeout();
        test_bad_marker();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
